mapper_bus_ctrl: RTL and testbench

- Parametrised second-generation Z80 MegaMapper bus controller for the Nabu CPLD.
- Decodes a relocatable 8-port mapper I/O window and holds a control register plus 2^SLOT_BITS page registers that drive high memory-address bits.
- Traps I/O accesses inside a configurable port window. On a trap it suppresses the system strobe, captures port and data, and signals the monitor with a timed NMI pulse through a trap state machine.
- Sits between the CPU bus and the system bus; mreq/iorq/irq pass through with gating.

---
 rtl/mapper_bus_ctrl.sv | 113 +++++++++++
 tb/tb_mapper_bus_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mapper_bus_ctrl.sv
// mapper_bus_ctrl: MegaMapper I/O window, slot page registers and port-trap NMI sequencer.
// Define TRAP_COUNT_EN to add a saturating trap counter readable at IO_BASE+3.
module mapper_bus_ctrl #(
    parameter logic [7:0] IO_BASE       = 8'h30,
    parameter int         SLOT_BITS     = 2,
    parameter int         PAGE_W        = 6,
    parameter logic [7:0] TRAP_BASE     = 8'h40,
    parameter logic [7:0] TRAP_MASK     = 8'hF0,
    parameter int         NMI_CYCLES    = 4,
    parameter logic [7:0] TRAP_READ_VAL = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    inout  wire  [7:0]           data,
    input  logic [7:0]           addr,
    input  logic [SLOT_BITS-1:0] addr_hi,
    input  logic                 wr_n,
    input  logic                 rd_n,
    input  logic                 iorq_n,
    input  logic                 mreq_n,
    input  logic                 m1_n,
    input  logic                 irq_sys_n,
    output logic                 iorq_sys_n,
    output logic                 mreq_sys_n,
    output logic                 irq_n,
    output logic                 nmi_n,
    output logic [PAGE_W-1:0]    page_out,
    output logic                 trap_state
);
    localparam int         NPG       = 1 << SLOT_BITS;
    localparam logic [7:0] CTRL_MASK = (SLOT_BITS > 2) ? 8'hC7 : 8'h07;
    typedef enum logic [1:0] {IDLE, CAPTURE, NMI, TRAPPED} state_t;
    state_t            r_state, w_next;
    logic [7:0]        r_ctrl, r_cap_port, r_cap_data, r_cnt;
    logic [PAGE_W-1:0] r_page [NPG];
    logic              r_wr_q;
    logic              w_io_cyc, w_map_io, w_trap_hit, w_reg_wr, w_ack, w_drive;
    logic [7:0]        w_pfull, w_reg_rd, w_tcnt;
    logic [PAGE_W-1:0] w_pval;
    assign w_io_cyc   = !iorq_n && m1_n;
    assign w_map_io   = w_io_cyc && addr[7:3] == IO_BASE[7:3];
    assign w_trap_hit = w_io_cyc && !w_map_io && (addr & TRAP_MASK) == TRAP_BASE && r_ctrl[1] && r_state == IDLE;
    assign w_reg_wr   = w_map_io && !wr_n && !r_wr_q;
    assign w_ack      = w_reg_wr && addr[2:0] == 3'd3;
    // Wider slot fields pick a bank of four page registers through ctrl[7:6].
    assign w_pfull    = (SLOT_BITS > 2) ? {4'b0, r_ctrl[7:6], addr[1:0]} : {6'b0, addr[1:0]};
    always_comb begin
        w_pval = '0;
        for (int k = 0; k < NPG; k++)
            if (w_pfull == 8'(k)) w_pval = r_page[k];
    end
    always_comb begin
        case (addr[2:0])
            3'd0:    w_reg_rd = r_cap_port;
            3'd1:    w_reg_rd = r_cap_data;
            3'd2:    w_reg_rd = r_ctrl;
            3'd3:    w_reg_rd = w_tcnt;
            default: w_reg_rd = 8'(w_pval);
        endcase
    end
    assign w_drive    = !rd_n && (w_map_io || r_state == CAPTURE);
    assign data       = w_drive ? (w_map_io ? w_reg_rd : TRAP_READ_VAL) : 8'bz;
    assign iorq_sys_n = iorq_n || w_map_io || w_trap_hit || r_state == CAPTURE;
    assign mreq_sys_n = mreq_n;
    assign irq_n      = irq_sys_n || r_ctrl[2];
    assign page_out   = r_ctrl[0] ? r_page[addr_hi] : PAGE_W'(addr_hi);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl     <= '0;
            r_cap_port <= '0;
            r_cap_data <= '0;
            r_cnt      <= '0;
            r_wr_q     <= 1'b0;
            for (int k = 0; k < NPG; k++) r_page[k] <= '0;
        end else begin
            r_wr_q <= w_io_cyc && !wr_n;
            if (w_reg_wr && addr[2:0] == 3'd2) r_ctrl <= data & CTRL_MASK;
            for (int k = 0; k < NPG; k++)
                if (w_reg_wr && addr[2] && w_pfull == 8'(k)) r_page[k] <= data[PAGE_W-1:0];
            if (w_trap_hit) begin
                r_cap_port <= addr;
                r_cap_data <= wr_n ? 8'h00 : data;
            end
            r_cnt <= r_state == CAPTURE ? 8'(NMI_CYCLES - 1) :
                     (r_state == NMI && r_cnt != 8'd0) ? r_cnt - 8'd1 : r_cnt;
        end
    end
`ifdef TRAP_COUNT_EN
    logic [7:0] r_tcnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_tcnt <= '0;
        else if (w_reg_wr && addr[2:0] == 3'd2 && data[7]) r_tcnt <= '0;
        else if (w_trap_hit && r_tcnt != 8'hFF) r_tcnt <= r_tcnt + 8'd1;
    end
    assign w_tcnt = r_tcnt;
`else
    assign w_tcnt = 8'h00;
`endif
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = (r_state == IDLE && w_trap_hit) ? CAPTURE :
                 (r_state == CAPTURE && iorq_n) ? NMI :
                 (r_state == NMI && r_cnt == 8'd0) ? TRAPPED :
                 (r_state == TRAPPED && w_ack) ? IDLE : r_state;
    end
    always_comb begin
        nmi_n      = r_state != NMI;
        trap_state = r_state != IDLE;
    end
endmodule

// File: tb/tb_mapper_bus_ctrl.sv
// tb_mapper_bus_ctrl: directed bench for the mapper bus controller with hand-computed expectations.
module tb_mapper_bus_ctrl;
    logic       clk = 1'b0, reset_n = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [1:0] addr_hi = 2'b00;
    logic       wr_n = 1'b1, rd_n = 1'b1, iorq_n = 1'b1, mreq_n = 1'b1, m1_n = 1'b1, irq_sys_n = 1'b1;
    logic       iorq_sys_n, mreq_sys_n, irq_n, nmi_n, trap_state;
    logic [5:0] page_out;
    logic [7:0] tb_dout = 8'h00;
    logic       tb_drv = 1'b0;
    wire  [7:0] data;
    int         n_cmp = 0, n_err = 0;
    logic [7:0] q;
    logic       s, ok;
    assign data = tb_drv ? tb_dout : 8'bz;
    always #5 clk = ~clk;
    mapper_bus_ctrl dut (
        .clk(clk), .reset_n(reset_n), .data(data), .addr(addr), .addr_hi(addr_hi),
        .wr_n(wr_n), .rd_n(rd_n), .iorq_n(iorq_n), .mreq_n(mreq_n), .m1_n(m1_n),
        .irq_sys_n(irq_sys_n), .iorq_sys_n(iorq_sys_n), .mreq_sys_n(mreq_sys_n),
        .irq_n(irq_n), .nmi_n(nmi_n), .page_out(page_out), .trap_state(trap_state)
    );
    // One Z80 I/O cycle: strobes set on a falling edge, held three clocks; reports read data and any system IORQ.
    task automatic bus_io(input logic [7:0] a, input logic wr, input logic [7:0] d,
                          output logic [7:0] rq, output logic sys_low);
        @(negedge clk);
        addr = a; m1_n = 1'b1; iorq_n = 1'b0; wr_n = !wr; rd_n = wr; tb_dout = d; tb_drv = wr;
        #1 sys_low = !iorq_sys_n; rq = data;
        repeat (3) begin
            @(posedge clk); #1;
            if (!iorq_sys_n) sys_low = 1'b1;
            rq = data;
        end
        @(negedge clk);
        iorq_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1; tb_drv = 1'b0;
    endtask
    task automatic wait_trapped(output logic done);
        logic seen;
        seen = 1'b0; done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (!nmi_n) seen = 1'b1;
            else if (seen) done = 1'b1;
        end
    endtask
    task automatic test_reset;
        reset_n = 1'b0; addr_hi = 2'b10; irq_sys_n = 1'b0; mreq_n = 1'b0; tb_dout = 8'h5A; tb_drv = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (nmi_n !== 1'b1) begin n_err++; $display("FAIL rst_nmi got %b exp 1", nmi_n); end
        n_cmp++; if (trap_state !== 1'b0) begin n_err++; $display("FAIL rst_trap_state got %b exp 0", trap_state); end
        n_cmp++; if (iorq_sys_n !== 1'b1) begin n_err++; $display("FAIL rst_iorq_sys got %b exp 1", iorq_sys_n); end
        n_cmp++; if (page_out !== 6'h02) begin n_err++; $display("FAIL rst_page got %h exp 02", page_out); end
        n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL rst_irq got %b exp 0", irq_n); end
        n_cmp++; if (mreq_sys_n !== 1'b0) begin n_err++; $display("FAIL rst_mreq got %b exp 0", mreq_sys_n); end
        n_cmp++; if (data !== 8'h5A) begin n_err++; $display("FAIL rst_bus got %h exp 5a", data); end
        tb_drv = 1'b0; mreq_n = 1'b1; irq_sys_n = 1'b1;
        @(negedge clk) reset_n = 1'b1;
        @(negedge clk) begin addr = 8'h10; iorq_n = 1'b0; rd_n = 1'b0; end
        #1;
        n_cmp++; if (iorq_sys_n !== 1'b0) begin n_err++; $display("FAIL pass_iorq_low got %b exp 0", iorq_sys_n); end
        n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL irq_follow got %b exp 1", irq_n); end
        @(negedge clk) begin iorq_n = 1'b1; rd_n = 1'b1; end
        #1;
        n_cmp++; if (iorq_sys_n !== 1'b1) begin n_err++; $display("FAIL pass_iorq_high got %b exp 1", iorq_sys_n); end
    endtask
    task automatic test_map;
        bus_io(8'h36, 1'b1, 8'h15, q, s);
        n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL map_wr_sys got %b exp 0", s); end
        bus_io(8'h32, 1'b1, 8'hF9, q, s);
        n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL ctrl_wr_sys got %b exp 0", s); end
        addr_hi = 2'b10; #1;
        n_cmp++; if (page_out !== 6'h15) begin n_err++; $display("FAIL page2_out got %h exp 15", page_out); end
        addr_hi = 2'b01; #1;
        n_cmp++; if (page_out !== 6'h00) begin n_err++; $display("FAIL page1_out got %h exp 00", page_out); end
        bus_io(8'h36, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h15) begin n_err++; $display("FAIL page2_rd got %h exp 15", q); end
        n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL map_rd_sys got %b exp 0", s); end
        bus_io(8'h32, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h01) begin n_err++; $display("FAIL ctrl_rd got %h exp 01", q); end
        bus_io(8'h34, 1'b1, 8'hFF, q, s);
        bus_io(8'h34, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h3F) begin n_err++; $display("FAIL page0_rd got %h exp 3f", q); end
        addr_hi = 2'b00; #1;
        n_cmp++; if (page_out !== 6'h3F) begin n_err++; $display("FAIL page0_out got %h exp 3f", page_out); end
        bus_io(8'h32, 1'b1, 8'h05, q, s);
        irq_sys_n = 1'b0; #1;
        n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL irq_mask got %b exp 1", irq_n); end
        irq_sys_n = 1'b1;
        bus_io(8'h33, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL p3_rd_idle got %h exp 00", q); end
    endtask
    task automatic test_trap;
        int lows;
        bus_io(8'h32, 1'b1, 8'h03, q, s);
        bus_io(8'h4A, 1'b1, 8'h5C, q, s);
        #1;
        n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL trap_sys got %b exp 0", s); end
        n_cmp++; if (trap_state !== 1'b1) begin n_err++; $display("FAIL trap_state got %b exp 1", trap_state); end
        n_cmp++; if (nmi_n !== 1'b1) begin n_err++; $display("FAIL nmi_early got %b exp 1", nmi_n); end
        lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (!nmi_n) lows++;
        end
        n_cmp++; if (lows !== 4) begin n_err++; $display("FAIL nmi_len got %0d exp 4", lows); end
        n_cmp++; if (trap_state !== 1'b1) begin n_err++; $display("FAIL trapped_state got %b exp 1", trap_state); end
        bus_io(8'h30, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h4A) begin n_err++; $display("FAIL cap_port got %h exp 4a", q); end
        bus_io(8'h31, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h5C) begin n_err++; $display("FAIL cap_data got %h exp 5c", q); end
        bus_io(8'h33, 1'b0, 8'h00, q, s);
`ifdef TRAP_COUNT_EN
        n_cmp++; if (q !== 8'h01) begin n_err++; $display("FAIL p3_rd got %h exp 01", q); end
`else
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL p3_rd got %h exp 00", q); end
`endif
    endtask
    task automatic test_trapped;
        bus_io(8'h41, 1'b1, 8'h00, q, s);
        n_cmp++; if (s !== 1'b1) begin n_err++; $display("FAIL trapped_pass got %b exp 1", s); end
        bus_io(8'h30, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h4A) begin n_err++; $display("FAIL cap_port_keep got %h exp 4a", q); end
        bus_io(8'h31, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h5C) begin n_err++; $display("FAIL cap_data_keep got %h exp 5c", q); end
        bus_io(8'h33, 1'b1, 8'h00, q, s);
        #1;
        n_cmp++; if (trap_state !== 1'b0) begin n_err++; $display("FAIL ack got %b exp 0", trap_state); end
        bus_io(8'h4A, 1'b1, 8'h11, q, s);
        #1;
        n_cmp++; if (trap_state !== 1'b1) begin n_err++; $display("FAIL retrap got %b exp 1", trap_state); end
        wait_trapped(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL retrap_nmi timeout got %b exp 1", ok); end
        bus_io(8'h31, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h11) begin n_err++; $display("FAIL retrap_data got %h exp 11", q); end
        bus_io(8'h33, 1'b1, 8'h00, q, s);
    endtask
    task automatic test_read_trap;
        bus_io(8'h47, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'hFF) begin n_err++; $display("FAIL trap_rd_val got %h exp ff", q); end
        n_cmp++; if (s !== 1'b0) begin n_err++; $display("FAIL trap_rd_sys got %b exp 0", s); end
        wait_trapped(ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL rd_trap timeout got %b exp 1", ok); end
        bus_io(8'h31, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rd_cap_data got %h exp 00", q); end
        bus_io(8'h30, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h47) begin n_err++; $display("FAIL rd_cap_port got %h exp 47", q); end
        bus_io(8'h33, 1'b1, 8'h00, q, s);
        @(negedge clk) begin addr = 8'h34; m1_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0; tb_dout = 8'hA5; tb_drv = 1'b1; end
        #1;
        n_cmp++; if (data !== 8'hA5) begin n_err++; $display("FAIL inta_bus got %h exp a5", data); end
        n_cmp++; if (iorq_sys_n !== 1'b0) begin n_err++; $display("FAIL inta_sys got %b exp 0", iorq_sys_n); end
        addr = 8'h44;
        @(posedge clk); #1;
        n_cmp++; if (trap_state !== 1'b0) begin n_err++; $display("FAIL inta_notrap got %b exp 0", trap_state); end
        @(negedge clk) begin m1_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; tb_drv = 1'b0; end
    endtask
    task automatic test_async_reset;
        bus_io(8'h4A, 1'b1, 8'h22, q, s);
        @(posedge clk); #1;
        n_cmp++; if (nmi_n !== 1'b0) begin n_err++; $display("FAIL pre_rst_nmi got %b exp 0", nmi_n); end
        #2 reset_n = 1'b0; addr_hi = 2'b10;
        #1;
        n_cmp++; if (nmi_n !== 1'b1) begin n_err++; $display("FAIL arst_nmi got %b exp 1", nmi_n); end
        n_cmp++; if (trap_state !== 1'b0) begin n_err++; $display("FAIL arst_state got %b exp 0", trap_state); end
        n_cmp++; if (page_out !== 6'h02) begin n_err++; $display("FAIL arst_page got %h exp 02", page_out); end
        @(negedge clk) reset_n = 1'b1;
        bus_io(8'h32, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL arst_ctrl got %h exp 00", q); end
        bus_io(8'h36, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL arst_page2 got %h exp 00", q); end
    endtask
`ifdef TRAP_COUNT_EN
    task automatic test_count;
        int tmo;
        tmo = 0;
        bus_io(8'h32, 1'b1, 8'h02, q, s);
        for (int i = 0; i < 300; i++) begin
            bus_io(8'h4A, 1'b1, 8'h00, q, s);
            wait_trapped(ok);
            if (!ok) tmo++;
            bus_io(8'h33, 1'b1, 8'h00, q, s);
        end
        n_cmp++; if (tmo !== 0) begin n_err++; $display("FAIL count_timeouts got %0d exp 0", tmo); end
        bus_io(8'h33, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'hFF) begin n_err++; $display("FAIL count_sat got %h exp ff", q); end
        bus_io(8'h32, 1'b1, 8'h82, q, s);
        bus_io(8'h33, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL count_clr got %h exp 00", q); end
        bus_io(8'h32, 1'b0, 8'h00, q, s);
        n_cmp++; if (q !== 8'h02) begin n_err++; $display("FAIL count_ctrl got %h exp 02", q); end
    endtask
`endif
    initial begin
        test_reset;
        test_map;
        test_trap;
        test_trapped;
        test_read_trap;
        test_async_reset;
`ifdef TRAP_COUNT_EN
        test_count;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
